// File: rtl/lif_stream_loader_pkg.sv
// Shared sizing and state encoding for the LIF stream loader.
// Optional spike-train capture is enabled by defining LIF_LOADER_SPIKE_TRAIN_EN.
package lif_stream_loader_pkg;

  localparam int unsigned N_STAGES   = 5;
  localparam int unsigned STEP_BITS  = 8;
  localparam int unsigned CNT_BITS   = 8;
  localparam int unsigned INPUTS     = 2 ** N_STAGES;
  localparam int unsigned NB         = (INPUTS / 8 > 1) ? INPUTS / 8 : 1;
  localparam int unsigned VEC_BITS   = NB * 8;
  localparam int unsigned IDX_BITS   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TRAIN_BITS = 32;

  typedef enum logic [2:0] {
    StIdle,
    StLoadW,
    StLoadX,
    StRun,
    StResp
  } state_e;

  // Narrow neuron configurations still send one whole byte.
  function automatic logic [VEC_BITS-1:0] zext_vec(input logic [INPUTS-1:0] v);
    return VEC_BITS'(v);
  endfunction

endpackage

// File: rtl/lif_stream_loader_if.sv
// Command, response and neuron-pin bundle for the LIF stream loader.
// rsp_train exists only when LIF_LOADER_SPIKE_TRAIN_EN is defined.
interface lif_stream_loader_if;
  import lif_stream_loader_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic                  cmd_load_w;
  logic [INPUTS-1:0]     cmd_weights;
  logic [INPUTS-1:0]     cmd_inputs;
  logic [STEP_BITS-1:0]  cmd_steps;
  logic [7:0]            lif_data;
  logic                  lif_sel_w;
  logic                  lif_run;
  logic                  lif_spike;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [CNT_BITS-1:0]   rsp_spikes;
`ifdef LIF_LOADER_SPIKE_TRAIN_EN
  logic [TRAIN_BITS-1:0] rsp_train;
`endif

  // Host and neuron side.
  modport master (
    output cmd_valid, cmd_load_w, cmd_weights, cmd_inputs, cmd_steps, rsp_ready, lif_spike,
`ifdef LIF_LOADER_SPIKE_TRAIN_EN
    input  rsp_train,
`endif
    input  cmd_ready, lif_data, lif_sel_w, lif_run, rsp_valid, rsp_spikes
  );

  // Loader side.
  modport slave (
    input  cmd_valid, cmd_load_w, cmd_weights, cmd_inputs, cmd_steps, rsp_ready, lif_spike,
`ifdef LIF_LOADER_SPIKE_TRAIN_EN
    output rsp_train,
`endif
    output cmd_ready, lif_data, lif_sel_w, lif_run, rsp_valid, rsp_spikes
  );

endinterface

// File: rtl/lif_stream_loader_serializer.sv
// Latches a neuron-width vector and presents it one byte per shift, MS byte first.
// Zeros fill in behind, so the output byte returns to 0 once the vector is drained.
module lif_stream_loader_serializer
  import lif_stream_loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [INPUTS-1:0] vec,
  input  logic              shift,
  output logic [7:0]        data,
  output logic              last
);

  logic [VEC_BITS-1:0] sreg_q;
  logic [IDX_BITS-1:0] idx_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sreg_q <= '0;
      idx_q  <= '0;
    end else if (load) begin
      sreg_q <= zext_vec(vec);
      idx_q  <= '0;
    end else if (shift) begin
      sreg_q <= sreg_q << 8;
      idx_q  <= last ? '0 : idx_q + 1'b1;
    end
  end

  assign data = sreg_q[VEC_BITS-1 -: 8];
  assign last = (idx_q == IDX_BITS'(NB - 1));

endmodule

// File: rtl/lif_stream_loader.sv
// Host-side driver for the LIF neuron: loads weights/inputs bytewise, integrates N steps,
// returns the saturating spike count. LIF_LOADER_SPIKE_TRAIN_EN adds a 32-bit spike history.
module lif_stream_loader
  import lif_stream_loader_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  lif_stream_loader_if.slave  bus
);

  state_e                state_q;
  logic [INPUTS-1:0]     inputs_q;
  logic [STEP_BITS-1:0]  step_cnt_q;
  logic [CNT_BITS-1:0]   cnt_q;
  logic                  cmd_ready_q;
  logic                  sel_w_q;
  logic                  run_q;
  logic                  rsp_valid_q;
  logic [TRAIN_BITS-1:0] train_q;

  logic              accept;
  logic              ser_load;
  logic              ser_shift;
  logic              ser_last;
  logic [INPUTS-1:0] ser_vec;
  logic [7:0]        ser_data;

  assign accept    = bus.cmd_valid & cmd_ready_q;
  assign ser_shift = (state_q == StLoadW) || (state_q == StLoadX);
  // Weights go first when requested; the latched inputs are reloaded as the last weight byte leaves.
  assign ser_load  = accept || ((state_q == StLoadW) && ser_last);
  assign ser_vec   = (state_q != StIdle) ? inputs_q :
                     bus.cmd_load_w      ? bus.cmd_weights : bus.cmd_inputs;

  lif_stream_loader_serializer u_serializer (
    .clk   (clk),
    .reset (reset),
    .load  (ser_load),
    .vec   (ser_vec),
    .shift (ser_shift),
    .data  (ser_data),
    .last  (ser_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      inputs_q    <= '0;
      step_cnt_q  <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      sel_w_q     <= 1'b0;
      run_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      train_q     <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (accept) begin
            inputs_q    <= bus.cmd_inputs;
            step_cnt_q  <= bus.cmd_steps;
            cnt_q       <= '0;
            train_q     <= '0;
            cmd_ready_q <= 1'b0;
            sel_w_q     <= bus.cmd_load_w;
            state_q     <= bus.cmd_load_w ? StLoadW : StLoadX;
          end
        end
        StLoadW: begin
          if (ser_last) begin
            sel_w_q <= 1'b0;
            state_q <= StLoadX;
          end
        end
        StLoadX: begin
          if (ser_last) begin
            if (step_cnt_q != '0) begin
              run_q   <= 1'b1;
              state_q <= StRun;
            end else begin
              rsp_valid_q <= 1'b1;
              state_q     <= StResp;
            end
          end
        end
        StRun: begin
          if (bus.lif_spike && (cnt_q != '1)) begin
            cnt_q <= cnt_q + 1'b1;
          end
          train_q    <= {train_q[TRAIN_BITS-2:0], bus.lif_spike};
          step_cnt_q <= step_cnt_q - 1'b1;
          if (step_cnt_q == STEP_BITS'(1)) begin
            run_q       <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= StIdle;
          end
        end
        default: begin
          state_q     <= StIdle;
          cmd_ready_q <= 1'b1;
          sel_w_q     <= 1'b0;
          run_q       <= 1'b0;
          rsp_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.lif_data   = ser_data;
  assign bus.lif_sel_w  = sel_w_q;
  assign bus.lif_run    = run_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_spikes = cnt_q;
`ifdef LIF_LOADER_SPIKE_TRAIN_EN
  assign bus.rsp_train  = train_q;
`else
  logic unused_train;
  assign unused_train = ^train_q;
`endif

endmodule

// File: tb/tb_lif_stream_loader.sv
// Directed self-checking bench for lif_stream_loader (N_STAGES=5, NB=4).
// Spike-train checks run only when LIF_LOADER_SPIKE_TRAIN_EN is defined.
module tb_lif_stream_loader;
  import lif_stream_loader_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lif_stream_loader_if bus ();

  lif_stream_loader dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Offers one command for one cycle, then scrambles the fields to prove they were latched.
  task automatic send(input logic lw, input logic [31:0] w, input logic [31:0] x,
                      input logic [7:0] s);
    bus.cmd_load_w  = lw;
    bus.cmd_weights = w;
    bus.cmd_inputs  = x;
    bus.cmd_steps   = s;
    bus.cmd_valid   = 1'b1;
    step();
    bus.cmd_valid   = 1'b0;
    bus.cmd_load_w  = ~lw;
    bus.cmd_weights = 32'hFFFF0000;
    bus.cmd_inputs  = 32'h5555AAAA;
    bus.cmd_steps   = 8'd77;
  endtask

  initial begin
    logic [31:0] w;
    int          cyc;

    bus.cmd_valid   = 1'b0;
    bus.cmd_load_w  = 1'b0;
    bus.cmd_weights = '0;
    bus.cmd_inputs  = '0;
    bus.cmd_steps   = '0;
    bus.rsp_ready   = 1'b0;
    bus.lif_spike   = 1'b0;
    reset = 1'b1;
    step();
    step();
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_lif_data", 32'(bus.lif_data), 32'd0);
    chk("rst_sel_w", 32'(bus.lif_sel_w), 32'd0);
    chk("rst_run", 32'(bus.lif_run), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_spikes", 32'(bus.rsp_spikes), 32'd0);
    reset = 1'b0;
    step();

    // Weights then inputs, no integration: response at T+9.
    w = 32'hA1B2C3D4;
    send(1'b1, w, 32'h0F0F0F0F, 8'd0);
    chk("a_cmd_ready_busy", 32'(bus.cmd_ready), 32'd0);
    for (int i = 0; i < 8; i++) begin
      chk("a_data", 32'(bus.lif_data), (i < 4) ? 32'(w[31-8*i -: 8]) : 32'h0F);
      chk("a_sel_w", 32'(bus.lif_sel_w), (i < 4) ? 32'd1 : 32'd0);
      chk("a_run", 32'(bus.lif_run), 32'd0);
      chk("a_rsp_early", 32'(bus.rsp_valid), 32'd0);
      step();
    end
    chk("a_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("a_rsp_spikes", 32'(bus.rsp_spikes), 32'd0);
    chk("a_resp_data", 32'(bus.lif_data), 32'd0);
    chk("a_resp_sel_w", 32'(bus.lif_sel_w), 32'd0);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("a_rsp_drop", 32'(bus.rsp_valid), 32'd0);
    chk("a_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);

    // Inputs only, 10 steps, spike on every other step: 5 spikes, response at T+15.
    send(1'b0, 32'hDEADBEEF, 32'hFFFFFFFF, 8'd10);
    for (int i = 0; i < 4; i++) begin
      chk("b_data", 32'(bus.lif_data), 32'hFF);
      chk("b_sel_w", 32'(bus.lif_sel_w), 32'd0);
      chk("b_run_load", 32'(bus.lif_run), 32'd0);
      step();
    end
    for (int i = 0; i < 10; i++) begin
      chk("b_run", 32'(bus.lif_run), 32'd1);
      chk("b_run_data", 32'(bus.lif_data), 32'd0);
      chk("b_run_sel_w", 32'(bus.lif_sel_w), 32'd0);
      chk("b_rsp_early", 32'(bus.rsp_valid), 32'd0);
      bus.lif_spike = (i % 2 == 0);
      step();
    end
    bus.lif_spike = 1'b0;
    chk("b_run_end", 32'(bus.lif_run), 32'd0);
    chk("b_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("b_rsp_spikes", 32'(bus.rsp_spikes), 32'd5);

    // Backpressure: response held, new command ignored.
    bus.cmd_load_w  = 1'b1;
    bus.cmd_steps   = 8'd3;
    bus.cmd_valid   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("h_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("h_rsp_spikes", 32'(bus.rsp_spikes), 32'd5);
      chk("h_run", 32'(bus.lif_run), 32'd0);
      chk("h_sel_w", 32'(bus.lif_sel_w), 32'd0);
      chk("h_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    end
    bus.cmd_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
    chk("h_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
    chk("h_rsp_drop", 32'(bus.rsp_valid), 32'd0);

    // 255 steps with the spike stuck high: count 255, response at T+260.
    bus.lif_spike = 1'b1;
    send(1'b0, 32'h0, 32'h0, 8'd255);
    cyc = 1;
    while (!bus.rsp_valid && cyc < 400) begin
      step();
      cyc++;
    end
    bus.lif_spike = 1'b0;
    chk("c_latency", 32'(cyc), 32'd260);
    chk("c_rsp_spikes", 32'(bus.rsp_spikes), 32'd255);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;

    // Reset during input load aborts the command.
    send(1'b0, 32'h0, 32'h12345678, 8'd5);
    chk("d_first_byte", 32'(bus.lif_data), 32'h12);
    step();
    chk("d_second_byte", 32'(bus.lif_data), 32'h34);
    reset = 1'b1;
    step();
    chk("d_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    chk("d_run", 32'(bus.lif_run), 32'd0);
    chk("d_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("d_data", 32'(bus.lif_data), 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("d_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("d_idle_run", 32'(bus.lif_run), 32'd0);

`ifdef LIF_LOADER_SPIKE_TRAIN_EN
    // Spike history: 1,0,1,1 lands as 4'b1011 with the last step in bit 0.
    send(1'b0, 32'h0, 32'h0, 8'd4);
    for (int i = 0; i < 4; i++) step();
    w = 32'h0000000B;
    for (int i = 0; i < 4; i++) begin
      bus.lif_spike = w[3-i];
      step();
    end
    bus.lif_spike = 1'b0;
    chk("e_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("e_rsp_train", bus.rsp_train, 32'hB);
    chk("e_rsp_spikes", 32'(bus.rsp_spikes), 32'd3);
    bus.rsp_ready = 1'b1;
    step();
    bus.rsp_ready = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
